jtag_param_dr: RTL and testbench

// - Parametrised JTAG test data register: Capture/Shift/Update stage plus parallel update latch.
// - Instantiated once per DR (IDCODE, user config, debug status) behind the TAP controller DR mux.
// - Generalises the fixed 32-bit ID register: arbitrary width, constant or live capture,

---
 rtl/jtag_param_dr.sv | 118 +++++++++++
 tb/tb_jtag_param_dr.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_param_dr.sv
// jtag_param_dr: parametrised JTAG test data register.
// The register captures a value, shifts it out LSB first while shifting TDI in, and
// commits the shifted value to a parallel update latch with a one-TCK strobe.
//
// Optional feature macro: DR_LENGTH_CHECK_EN
//   When this macro is defined, an update commits only if exactly WIDTH shifts happened
//   since the last capture. A wrong length sets a sticky len_err instead.
//   When it is undefined, every update commits and len_err is tied low.
//
// Ports:
//   TCK           JTAG test clock; all state changes on posedge
//   TRST          JTAG reset, asynchronous, active-low
//   TDI           serial data in
//   TDO           serial data out, equal to sr[0]; combinational, because the TAP mux retimes it
//   dr_select     this DR is selected by the current instruction
//   capture_dr    TAP is in Capture-DR
//   shift_dr      TAP is in Shift-DR
//   update_dr     TAP is in Update-DR
//   tlr_reset     TAP is in Test-Logic-Reset; acts as a synchronous reset
//   capture_data  parallel capture value, used only when CAPTURE_MODE=1
//   update_data   parallel update latch
//   update_strobe one-TCK pulse that comes with each change of update_data
//   len_err       sticky shift-length error
module jtag_param_dr #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      CAPTURE_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE  = WIDTH'(32'h1000_1003),
  parameter logic [WIDTH-1:0] UPDATE_RESET = '0
) (
  input  logic             TCK,
  input  logic             TRST,
  input  logic             TDI,
  output logic             TDO,
  input  logic             dr_select,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic             tlr_reset,
  input  logic [WIDTH-1:0] capture_data,
  output logic [WIDTH-1:0] update_data,
  output logic             update_strobe,
  output logic             len_err
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] ur;
  logic             do_capture_c;
  logic             do_shift_c;
  logic             do_update_c;
  logic             commit_c;
  logic [WIDTH-1:0] capture_value_c;

  // Decode the TAP controls with priority capture > shift > update (tlr_reset is above all of them)
  assign do_capture_c    = dr_select & capture_dr;
  assign do_shift_c      = dr_select & shift_dr & ~capture_dr;
  assign do_update_c     = dr_select & update_dr & ~capture_dr & ~shift_dr;
  assign capture_value_c = (CAPTURE_MODE != 0) ? capture_data : RESET_VALUE;

  assign TDO         = sr[0];
  assign update_data = ur;

  // Shift stage, update latch and strobe
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      sr            <= RESET_VALUE;
      ur            <= UPDATE_RESET;
      update_strobe <= 1'b0;
    end else if (tlr_reset) begin
      sr            <= RESET_VALUE;
      ur            <= UPDATE_RESET;
      update_strobe <= 1'b0;
    end else begin
      update_strobe <= 1'b0;
      if (do_capture_c) begin
        sr <= capture_value_c;
      end else if (do_shift_c) begin
        sr <= {TDI, sr[WIDTH-1:1]};
      end else if (do_update_c && commit_c) begin
        ur            <= sr;
        update_strobe <= 1'b1;
      end
    end
  end

`ifdef DR_LENGTH_CHECK_EN
  localparam int unsigned CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH + 1);

  logic [CNT_W-1:0] cnt;

  assign commit_c = (cnt == CNT_FULL);

  // Shift counter: it saturates one count above WIDTH, so an over-length shift cannot wrap back to WIDTH
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      cnt     <= '0;
      len_err <= 1'b0;
    end else if (tlr_reset) begin
      cnt     <= '0;
      len_err <= 1'b0;
    end else if (do_capture_c) begin
      cnt     <= '0;
      len_err <= 1'b0;
    end else if (do_shift_c) begin
      if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (do_update_c && !commit_c) begin
      len_err <= 1'b1;
    end
  end
`else
  assign commit_c = 1'b1;
  assign len_err  = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_param_dr.sv
// Scoreboard bench for jtag_param_dr. Two instances share the controls:
// u0 uses mode 0 (it captures RESET_VALUE) and u1 uses mode 1 (it captures capture_data).
module tb_jtag_param_dr;

  localparam int unsigned W  = 32;
  localparam logic [31:0] RV = 32'h1000_1003;
`ifdef DR_LENGTH_CHECK_EN
  localparam bit LCHK = 1'b1;
`else
  localparam bit LCHK = 1'b0;
`endif

  logic        TCK = 1'b0;
  logic        TRST = 1'b0;
  logic        TDI = 1'b0;
  logic        dr_select = 1'b0, capture_dr = 1'b0, shift_dr = 1'b0;
  logic        update_dr = 1'b0, tlr_reset = 1'b0;
  logic [31:0] capture_data = '0;
  logic        tdo0, tdo1, st0, st1, le0, le1;
  logic [31:0] ud0, ud1;

  always #5 TCK = ~TCK;

  jtag_param_dr #(.WIDTH(W), .CAPTURE_MODE(0)) u0 (
    .TCK(TCK), .TRST(TRST), .TDI(TDI), .TDO(tdo0), .dr_select(dr_select),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .tlr_reset(tlr_reset), .capture_data(capture_data), .update_data(ud0),
    .update_strobe(st0), .len_err(le0));

  jtag_param_dr #(.WIDTH(W), .CAPTURE_MODE(1)) u1 (
    .TCK(TCK), .TRST(TRST), .TDI(TDI), .TDO(tdo1), .dr_select(dr_select),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .tlr_reset(tlr_reset), .capture_data(capture_data), .update_data(ud1),
    .update_strobe(st1), .len_err(le1));

  typedef struct packed {
    logic [1:0]  tdo;
    logic [1:0]  st;
    logic [1:0]  le;
    logic [31:0] ud1;
    logic [31:0] ud0;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: the register's contents as a plain value, its update value, the number of bits shifted since the last capture, and the error flag
  logic [31:0] m_sr [2];
  logic [31:0] m_ur [2];
  int          m_cnt[2];
  logic        m_le [2];
  logic        m_st [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sr[i] = RV; m_ur[i] = '0; m_cnt[i] = 0; m_le[i] = 1'b0; m_st[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic tlr, cap, sh, upd, sel, tdi, input logic [31:0] cd);
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 1'b0;
      if (tlr) begin
        m_sr[i] = RV; m_ur[i] = '0; m_cnt[i] = 0; m_le[i] = 1'b0;
      end else if (sel && cap) begin
        m_sr[i] = (i == 1) ? cd : RV; m_cnt[i] = 0; m_le[i] = 1'b0;
      end else if (sel && sh) begin
        m_sr[i] = (m_sr[i] >> 1) | (32'(tdi) << 31);
        m_cnt[i] = (m_cnt[i] + 1 > W + 1) ? W + 1 : m_cnt[i] + 1;
      end else if (sel && upd) begin
        if (!LCHK || m_cnt[i] == W) begin
          m_ur[i] = m_sr[i]; m_st[i] = 1'b1;
        end else begin
          m_le[i] = 1'b1;
        end
      end
    end
  endtask

  // One TCK cycle of stimulus; the expected post-edge outputs go to the scoreboard
  task automatic step(input logic tlr, cap, sh, upd, sel, tdi, input logic [31:0] cd);
    exp_t e;
    @(negedge TCK);
    tlr_reset = tlr; capture_dr = cap; shift_dr = sh; update_dr = upd;
    dr_select = sel; TDI = tdi; capture_data = cd;
    model_edge(tlr, cap, sh, upd, sel, tdi, cd);
    e.tdo = {m_sr[1][0], m_sr[0][0]};
    e.st  = {m_st[1], m_st[0]};
    e.le  = {m_le[1], m_le[0]};
    e.ud1 = m_ur[1];
    e.ud0 = m_ur[0];
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1, 0, capture_data);
  endtask

  task automatic capture(input logic [31:0] cd);
    step(0, 1, 0, 0, 1, 0, cd);
  endtask

  task automatic shift_word(input logic [31:0] d, input int n);
    for (int k = 0; k < n; k++) step(0, 0, 1, 0, 1, d[k % 32], capture_data);
  endtask

  task automatic update();
    step(0, 0, 0, 1, 1, 0, capture_data);
  endtask

  // Monitor: after each posedge, pop the pending expectation and compare every output
  always @(posedge TCK) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("tdo0", 32'(tdo0), 32'(e.tdo[0]));
      chk("tdo1", 32'(tdo1), 32'(e.tdo[1]));
      chk("strobe0", 32'(st0), 32'(e.st[0]));
      chk("strobe1", 32'(st1), 32'(e.st[1]));
      chk("len_err0", 32'(le0), 32'(e.le[0]));
      chk("len_err1", 32'(le1), 32'(e.le[1]));
      chk("update_data0", ud0, e.ud0);
      chk("update_data1", ud1, e.ud1);
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tdo0"}, 32'(tdo0), 32'(RV[0]));
    chk({tag, "_tdo1"}, 32'(tdo1), 32'(RV[0]));
    chk({tag, "_ud0"}, ud0, 32'h0);
    chk({tag, "_ud1"}, ud1, 32'h0);
    chk({tag, "_strobe"}, 32'({st1, st0}), 32'h0);
    chk({tag, "_len_err"}, 32'({le1, le0}), 32'h0);
  endtask

  initial begin
    int n;
    int kind;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge TCK);
    TRST = 1'b1;

    // Mode 0: capture and shift 32 zeros, so the ID streams out of TDO
    capture(32'h0);
    shift_word(32'h0, 32);
    update();
    idle(2);

    // Mode 1: capture A5A55A5A, shift in DEADBEEF, update once
    capture(32'hA5A5_5A5A);
    shift_word(32'hDEAD_BEEF, 32);
    update();
    idle(2);

    // Short shift, then a second capture that clears any length error
    capture(32'h1234_5678);
    shift_word(32'hCAFE_F00D, 31);
    update();
    idle(2);
    capture(32'h0F0F_0F0F);
    idle(1);

    // Pause in the middle of a shift: the count continues across the idle cycles
    capture(32'h3C3C_C3C3);
    shift_word(32'h8765_4321, 16);
    idle(3);
    shift_word(32'h0000_8765, 16);
    update();
    update();
    idle(2);

    // Ten shifts, then Test-Logic-Reset
    capture(32'hFFFF_FFFF);
    shift_word(32'h0000_02AA, 10);
    step(1, 0, 0, 0, 0, 0, capture_data);
    idle(1);

    // While dr_select is low, capture, shift and update pulses are ignored
    step(0, 1, 0, 0, 0, 1, 32'h5555_AAAA);
    step(0, 0, 1, 0, 0, 1, 32'h5555_AAAA);
    step(0, 0, 0, 1, 0, 1, 32'h5555_AAAA);
    idle(1);

    // Random complete transactions with lengths near WIDTH; a length of 33 or more saturates the count
    for (int t = 0; t < 24; t++) begin
      capture($urandom);
      n = 30 + int'($urandom_range(0, 5));
      if (n > 33) n = 32;
      shift_word($urandom, n / 2);
      if ($urandom_range(0, 1) != 0) idle(int'($urandom_range(1, 3)));
      shift_word($urandom, n - n / 2);
      update();
      if ($urandom_range(0, 2) == 0) update();
      idle(int'($urandom_range(0, 2)));
    end

    // Unconstrained control mix, including cycles that assert several controls at once
    for (int t = 0; t < 300; t++) begin
      kind = int'($urandom_range(0, 99));
      if (kind < 6)       step(0, 1, 0, 0, $urandom_range(0, 9) != 0, $urandom_range(0, 1) != 0, $urandom);
      else if (kind < 70) step(0, 0, 1, 0, $urandom_range(0, 9) != 0, $urandom_range(0, 1) != 0, capture_data);
      else if (kind < 80) step(0, 0, 0, 1, $urandom_range(0, 9) != 0, 0, capture_data);
      else if (kind < 82) step(1, 0, 0, 0, $urandom_range(0, 1) != 0, 0, capture_data);
      else if (kind < 88) step($urandom_range(0, 7) == 0, $urandom_range(0, 1) != 0,
                               $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                               1'b1, $urandom_range(0, 1) != 0, $urandom);
      else                step(0, 0, 0, 0, $urandom_range(0, 1) != 0, 0, capture_data);
    end

    // Asynchronous TRST in the middle of a shift
    capture(32'h7777_1111);
    shift_word(32'hABCD_EF01, 7);
    @(posedge TCK);
    #3;
    TRST = 1'b0;
    capture_dr = 0; shift_dr = 0; update_dr = 0; tlr_reset = 0; dr_select = 0;
    model_reset();
    #1;
    check_reset_outputs("trst_mid");
    @(negedge TCK);
    TRST = 1'b1;
    capture(32'h0);
    shift_word(32'h0, 4);
    idle(2);

    repeat (3) @(posedge TCK);
    #2;
    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
